sync_transmitter: RTL and testbench

Serial transmitter that is the counterpart to the team's Sync_Reciver. It takes a 32-bit parallel word through a send/busy handshake. It serialises the word as one frame: start bit, data LSB first, optional parity bit, stop bit(s). Bit timing comes from the shared CLK_Baud tick enable, so a transmitter and a receiver on the same baud tick interoperate directly.

---
 rtl/sync_transmitter.sv | 156 +++++++++++++++
 tb/tb_sync_transmitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_transmitter.sv
// sync_transmitter: frames a parallel word onto a serial line.
// Frame order is start (0), data LSB first, optional parity, then stop bit(s) (1).
// One CLK_Baud tick is one bit period, so the frame matches a receiver on the same tick.
//
// Ports:
//   CLK           system clock, rising edge
//   CLR           asynchronous active-low reset
//   CLK_Baud      one-cycle tick enable; one tick = one bit period
//   Send          transmit request, sampled only while Busy=0
//   Data_in       word to transmit, captured on the accept edge
//   Serial_output serial line, idle high (registered)
//   Busy          high from the cycle after accept until the frame completes (registered)
//   TX_Done       one-cycle pulse on frame completion (registered)
`timescale 1ns/1ps
module sync_transmitter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CLK_Baud,
  input  logic                  Send,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic                  Serial_output,
  output logic                  Busy,
  output logic                  TX_Done
);

  localparam int unsigned     CntW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit  = CntW'(DATA_WIDTH - 1);
  // The stop counter only has to tell the first stop period from the second.
  localparam logic            LastStop = (STOP_BITS > 1) ? 1'b1 : 1'b0;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StStart  = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StParity = 3'd4;
  localparam logic [2:0] StStop   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  stop_q, stop_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;
    line_d  = line_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Busy is low in this state only, so this is the whole accept condition.
        // A tick on the accept edge is deliberately not used.
        if (Send) begin
          shift_d = Data_in;
          par_d   = (^Data_in) ^ PARITY_ODD;
          busy_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (CLK_Baud) begin
          line_d  = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (CLK_Baud) begin
          line_d  = shift_q[0];
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (CLK_Baud) begin
          if (cnt_q == LastBit) begin
            if (PARITY_EN) begin
              line_d  = par_q;
              state_d = StParity;
            end else begin
              line_d  = 1'b1;
              stop_d  = 1'b0;
              state_d = StStop;
            end
          end else begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            line_d  = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (CLK_Baud) begin
          line_d  = 1'b1;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (CLK_Baud) begin
          if (stop_q == LastStop) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        line_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Serial_output = line_q;
  assign Busy          = busy_q;
  assign TX_Done       = done_q;

endmodule

// File: tb/tb_sync_transmitter.sv
// Directed bench for sync_transmitter. Four instances share clock, reset, tick and data:
// [0] defaults, [1] odd parity, [2] no parity, [3] two stop bits.
`timescale 1ns/1ps
module tb_sync_transmitter;

  logic        clk = 1'b0;
  logic        clr;
  logic        tick = 1'b0;
  logic        tick_en;
  int          div;
  int          bcnt = 0;
  logic [3:0]  send;
  logic [31:0] data_in;
  logic [3:0]  line, busy, done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Tick changes only on falling edges, so it is stable across each rising edge.
  always @(negedge clk) begin
    if (!tick_en) begin
      tick = 1'b0;
      bcnt = 0;
    end else if (bcnt >= div - 1) begin
      tick = 1'b1;
      bcnt = 0;
    end else begin
      tick = 1'b0;
      bcnt++;
    end
  end

  sync_transmitter #(.DATA_WIDTH(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_even (
    .CLK(clk), .CLR(clr), .CLK_Baud(tick), .Send(send[0]), .Data_in(data_in),
    .Serial_output(line[0]), .Busy(busy[0]), .TX_Done(done[0]));
  sync_transmitter #(.DATA_WIDTH(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_odd (
    .CLK(clk), .CLR(clr), .CLK_Baud(tick), .Send(send[1]), .Data_in(data_in),
    .Serial_output(line[1]), .Busy(busy[1]), .TX_Done(done[1]));
  sync_transmitter #(.DATA_WIDTH(32), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_nopar (
    .CLK(clk), .CLR(clr), .CLK_Baud(tick), .Send(send[2]), .Data_in(data_in),
    .Serial_output(line[2]), .Busy(busy[2]), .TX_Done(done[2]));
  sync_transmitter #(.DATA_WIDTH(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_stop2 (
    .CLK(clk), .CLR(clr), .CLK_Baud(tick), .Send(send[3]), .Data_in(data_in),
    .Serial_output(line[3]), .Busy(busy[3]), .TX_Done(done[3]));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses Send for one accept edge (or leaves it high), then scrambles Data_in.
  task automatic accept(input int idx, input logic [31:0] word, input bit hold, input string tag);
    @(negedge clk);
    send[idx] = 1'b1;
    data_in   = word;
    @(posedge clk);
    #1;
    if (!hold) send[idx] = 1'b0;
    data_in = ~word;
    check_eq({tag, " busy after accept"}, 64'(busy[idx]), 64'd1);
  endtask

  // Records the line at every tick edge until TX_Done, with optional mid-frame
  // Send injection or reset after the given number of recorded bits.
  task automatic capture(input int idx, input int inject_at, input int abort_at,
                         output logic [63:0] bits, output int nbits, output int ndone,
                         output bit pre_hi, output bit busy_at_done, output bit stable,
                         output bit busy_kept);
    logic prev;
    bits = '0; nbits = 0; ndone = 0; pre_hi = 1'b1; busy_at_done = 1'b1;
    stable = 1'b1; busy_kept = 1'b1;
    prev = line[idx];
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (inject_at >= 0 && send[idx]) send[idx] = 1'b0;
      if (done[idx]) begin
        ndone = 1;
        busy_at_done = busy[idx];
        break;
      end
      if (!busy[idx]) busy_kept = 1'b0;
      if (tick) begin
        if (nbits < 64) bits[nbits] = line[idx];
        nbits++;
        prev = line[idx];
        if (nbits == inject_at) begin
          send[idx] = 1'b1;
          data_in   = 32'h1234_5678;
        end
        if (nbits == abort_at) begin
          clr = 1'b0;
          #1;
          break;
        end
      end else begin
        if (line[idx] !== prev) stable = 1'b0;
        if (nbits == 0 && line[idx] !== 1'b1) pre_hi = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input int idx, input logic [31:0] word, input logic par,
                             input string tag);
    logic [63:0] bits, exp;
    int nbits, ndone, pos;
    bit pre_hi, bad, stable, kept;
    capture(idx, -1, -1, bits, nbits, ndone, pre_hi, bad, stable, kept);
    exp = '0;
    exp[0] = 1'b0;
    for (int i = 0; i < 32; i++) exp[1+i] = word[i];
    pos = 33;
    if (idx != 2) begin
      exp[pos] = par;
      pos++;
    end
    exp[pos] = 1'b1;
    pos++;
    if (idx == 3) begin
      exp[pos] = 1'b1;
      pos++;
    end
    check_eq({tag, " done"}, 64'(ndone), 64'd1);
    check_eq({tag, " bit periods"}, 64'(nbits), 64'(pos));
    check_eq({tag, " frame bits"}, bits, exp);
    check_eq({tag, " busy at done"}, 64'(bad), 64'd0);
    check_eq({tag, " idle high before start"}, 64'(pre_hi), 64'd1);
    check_eq({tag, " line only moves on tick"}, 64'(stable), 64'd1);
    check_eq({tag, " busy held in frame"}, 64'(kept), 64'd1);
  endtask

  task automatic do_frame(input int idx, input logic [31:0] word, input logic par,
                          input string tag, input bit hold);
    accept(idx, word, hold, tag);
    check_frame(idx, word, par, tag);
  endtask

  // Watches an idle instance for a while; Busy or TX_Done must not appear.
  task automatic check_quiet(input int idx, input int cycles, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (busy[idx] || done[idx] || line[idx] !== 1'b1) seen = 1'b1;
    end
    check_eq({tag, " stays idle"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] bits;
    int nbits, ndone;
    bit pre_hi, bad, stable, kept;

    clr = 1'b0; send = '0; data_in = '0; tick_en = 1'b1; div = 16;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("reset line", 64'(line[i]), 64'd1);
      check_eq("reset busy", 64'(busy[i]), 64'd0);
      check_eq("reset done", 64'(done[i]), 64'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (5) @(posedge clk);

    // Basic frame: 16 ones -> even parity 0.
    do_frame(0, 32'hA5A5_0F0F, 1'b0, "t1", 1'b0);

    // Parity modes and frame shapes.
    do_frame(0, 32'h0000_0001, 1'b1, "t2 even", 1'b0);
    do_frame(1, 32'h0000_0001, 1'b0, "t2 odd", 1'b0);
    do_frame(2, 32'h0000_0001, 1'b0, "t2 nopar", 1'b0);
    do_frame(3, 32'hA5A5_0F0F, 1'b0, "t2 stop2", 1'b0);

    // Word set from the receiver interop list, checked against the frame model.
    do_frame(0, 32'h0000_0000, 1'b0, "t3 zero", 1'b0);
    do_frame(0, 32'hFFFF_FFFF, 1'b0, "t3 ones", 1'b0);
    do_frame(0, 32'hDEAD_BEEF, 1'b0, "t3 dead", 1'b0);

    // Send held high: each next word goes in on the TX_Done cycle.
    do_frame(0, 32'h1111_1111, 1'b0, "t4 w0", 1'b1);
    do_frame(0, 32'h8000_0000, 1'b1, "t4 w1", 1'b1);
    do_frame(0, 32'h0F0F_0F0F, 1'b0, "t4 w2", 1'b1);
    send[0] = 1'b0;
    check_quiet(0, 40, "t4 after queue");

    // Send pulse at bit 10 of an active frame is ignored.
    accept(0, 32'hC3C3_3C3C, 1'b0, "t5");
    capture(0, 10, -1, bits, nbits, ndone, pre_hi, bad, stable, kept);
    check_eq("t5 done", 64'(ndone), 64'd1);
    check_eq("t5 bit periods", 64'(nbits), 64'd35);
    check_eq("t5 frame bits", bits, {29'd0, 1'b1, 1'b0, 32'hC3C3_3C3C, 1'b0});
    check_quiet(0, 100, "t5 no extra frame");

    // Asynchronous reset at bit 20.
    accept(0, 32'hFFFF_0000, 1'b0, "t6");
    capture(0, -1, 20, bits, nbits, ndone, pre_hi, bad, stable, kept);
    check_eq("t6 bits before reset", 64'(nbits), 64'd20);
    check_eq("t6 line in reset", 64'(line[0]), 64'd1);
    check_eq("t6 busy in reset", 64'(busy[0]), 64'd0);
    check_eq("t6 done in reset", 64'(done[0]), 64'd0);
    @(negedge clk);
    clr = 1'b1;
    check_quiet(0, 40, "t6 after release");
    do_frame(0, 32'h5555_AAAA, 1'b0, "t6 resend", 1'b0);

    // Fastest rate: tick on every cycle.
    div = 1;
    repeat (2) @(posedge clk);
    do_frame(0, 32'hDEAD_BEEF, 1'b0, "fast", 1'b0);
    div = 16;

    // Tick stuck low holds the frame in its waiting state.
    @(negedge clk);
    tick_en = 1'b0;
    accept(0, 32'h0000_00F0, 1'b0, "frozen");
    repeat (100) @(posedge clk);
    #1;
    check_eq("frozen line", 64'(line[0]), 64'd1);
    check_eq("frozen busy", 64'(busy[0]), 64'd1);
    @(negedge clk);
    tick_en = 1'b1;
    check_frame(0, 32'h0000_00F0, 1'b0, "frozen");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
